instr_fetch_controller: RTL and testbench

//  Sequences the word-addressed, synchronous-read instruction memory for the non-pipelined MIPS core.

---
 rtl/instr_fetch_controller_if.sv | 28 ++
 rtl/instr_fetch_controller.sv | 107 ++++++++++
 tb/tb_instr_fetch_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_controller_if.sv
// Fetch-controller bus: instruction-memory port, datapath issue handshake,
// completion report and run control/status.
interface instr_fetch_controller_if;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        exec_done;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        busy;
  logic [31:0] retired;
  logic        fault;

  modport master (
    input  start, imem_instr, instr_ready, exec_done, redirect, redirect_pc, halt_req,
    output imem_addr, instr, instr_pc, instr_valid, busy, retired, fault
  );

  modport slave (
    output start, imem_instr, instr_ready, exec_done, redirect, redirect_pc, halt_req,
    input  imem_addr, instr, instr_pc, instr_valid, busy, retired, fault
  );
endinterface

// File: rtl/instr_fetch_controller.sv
// PC owner and fetch/issue/execute sequencer for the non-pipelined MIPS core.
// Optional out-of-range fetch trap is enabled with `define IFC_BOUND_CHECK_EN.
module instr_fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input logic                       clk,
  input logic                       rst_n,
  instr_fetch_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_retired;
  logic [31:0] w_word_addr;
  logic [31:0] w_redirect_target;
  logic        w_start_ok;
  logic        w_oob;
  logic        w_unused;

  assign w_word_addr       = {2'b00, r_pc[31:2]};
  assign w_redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign w_start_ok        = bus.start && (r_state == S_IDLE || r_state == S_HALTED);
  assign w_oob             = (w_word_addr >= IMEM_DEPTH);

  assign bus.imem_addr   = w_word_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = (r_state == S_ISSUE);
  assign bus.busy        = !(r_state == S_IDLE || r_state == S_HALTED);
  assign bus.retired     = r_retired;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default is assigned first so no path through the case leaves
  // w_next_state unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (bus.start) w_next_state = S_FETCH;
      S_FETCH: begin
        w_next_state = S_WAIT;
`ifdef IFC_BOUND_CHECK_EN
        if (w_oob) w_next_state = S_HALTED;
`endif
      end
      S_WAIT:  w_next_state = S_ISSUE;
      S_ISSUE: if (bus.instr_ready) w_next_state = S_EXEC;
      S_EXEC:  if (bus.exec_done) w_next_state = bus.halt_req ? S_HALTED : S_FETCH;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_retired  <= 32'h0;
    end else begin
      if (w_start_ok) r_pc <= RESET_PC;
      // The memory has no reset; only the word landing during WAIT is trusted.
      if (r_state == S_WAIT) begin
        r_instr    <= bus.imem_instr;
        r_instr_pc <= r_pc;
      end
      if (r_state == S_EXEC && bus.exec_done) begin
        r_pc      <= bus.redirect ? w_redirect_target : r_pc + 32'd4;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

`ifdef IFC_BOUND_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n)                           r_fault <= 1'b0;
    else if (w_start_ok)                  r_fault <= 1'b0;
    else if (r_state == S_FETCH && w_oob) r_fault <= 1'b1;
  end

  assign bus.fault = r_fault;
  assign w_unused  = ^bus.redirect_pc[1:0];
`else
  assign bus.fault = 1'b0;
  assign w_unused  = ^{bus.redirect_pc[1:0], w_oob};
`endif

endmodule

// File: tb/tb_instr_fetch_controller.sv
// Scoreboard bench: issued instructions are queued as expected {instr, pc} and
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_instr_fetch_controller;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] mem [512];
  exp_t exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_controller_if bus ();

  instr_fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory model
  always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr[8:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_pc", bus.instr_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_instr", bus.instr, e.instr);
        check("issue_pc", bus.instr_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.instr = mem[pc[10:2]];
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("instr_valid_timeout", {31'h0, bus.instr_valid}, 32'h1);
  endtask

  // Called with instr_valid high and ready high: accept, exec_done 2 cycles later.
  task automatic finish_instr(input logic redir, input logic [31:0] rpc, input logic halt);
    tick();
    tick();
    bus.exec_done   = 1'b1;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.halt_req    = halt;
    tick();
    bus.exec_done   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_req    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] held_instr;
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 + i;
    mem[0] = 32'h8C01_0020;
    mem[1] = 32'h8C02_0020;
    mem[2] = 32'h0000_0000;

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.exec_done   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_req    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_valid",   {31'h0, bus.instr_valid}, 32'h0);
    check("rst_busy",    {31'h0, bus.busy}, 32'h0);
    check("rst_retired", bus.retired, 32'h0);
    check("rst_fault",   {31'h0, bus.fault}, 32'h0);
    check("rst_addr",    bus.imem_addr, 32'h0);

    // Sequential fetch of three words, valid three cycles after start
    bus.instr_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    pulse_start();
    check("lat_c1_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("lat_c1_busy",  {31'h0, bus.busy}, 32'h1);
    tick();
    check("lat_c2_valid", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    check("lat_c3_valid", {31'h0, bus.instr_valid}, 32'h1);
    finish_instr(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_valid();
      finish_instr(1'b0, 32'h0, 1'b0);
    end
    check("seq_retired", bus.retired, 32'd3);

    // Redirect with unaligned target: low bits dropped
    push_exp(32'hC);
    wait_valid();
    finish_instr(1'b1, 32'h0000_0013, 1'b0);
    check("redir_addr", bus.imem_addr, 32'd4);
    push_exp(32'h10);
    wait_valid();
    finish_instr(1'b0, 32'h0, 1'b0);

    // Backpressure, with a stray exec_done that must be ignored
    bus.instr_ready = 1'b0;
    wait_valid();
    held_instr = bus.instr;
    for (int k = 0; k < 5; k++) begin
      bus.exec_done   = (k == 2);
      bus.redirect    = (k == 2);
      bus.redirect_pc = 32'h100;
      tick();
      check("bp_valid", {31'h0, bus.instr_valid}, 32'h1);
      check("bp_instr", bus.instr, held_instr);
      check("bp_addr",  bus.imem_addr, 32'd5);
    end
    bus.exec_done = 1'b0;
    bus.redirect  = 1'b0;
    check("bp_retired", bus.retired, 32'd5);
    push_exp(32'h14);
    bus.instr_ready = 1'b1;
    finish_instr(1'b0, 32'h0, 1'b0);

    // Halt together with exec_done at pc=4
    push_exp(32'h18);
    wait_valid();
    finish_instr(1'b1, 32'h4, 1'b0);
    push_exp(32'h4);
    wait_valid();
    finish_instr(1'b0, 32'h0, 1'b1);
    check("halt_busy",    {31'h0, bus.busy}, 32'h0);
    check("halt_addr",    bus.imem_addr, 32'd2);
    check("halt_retired", bus.retired, 32'd8);
    repeat (3) tick();
    check("halt_hold_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("halt_hold_addr",  bus.imem_addr, 32'd2);

    push_exp(32'h0);
    pulse_start();
    check("resume_addr", bus.imem_addr, 32'd0);
    wait_valid();
    finish_instr(1'b0, 32'h0, 1'b0);

    // Out-of-range target
    push_exp(32'h4);
    wait_valid();
    finish_instr(1'b1, 32'h400, 1'b0);
    check("oob_addr", bus.imem_addr, 32'd256);
`ifdef IFC_BOUND_CHECK_EN
    tick();
    check("oob_fault", {31'h0, bus.fault}, 32'h1);
    check("oob_busy",  {31'h0, bus.busy}, 32'h0);
    repeat (3) tick();
    check("oob_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("oob_retired", bus.retired, 32'd10);
    push_exp(32'h0);
    pulse_start();
    check("oob_fault_clear", {31'h0, bus.fault}, 32'h0);
    wait_valid();
    finish_instr(1'b0, 32'h0, 1'b0);
`else
    tick();
    check("oob_fault", {31'h0, bus.fault}, 32'h0);
    push_exp(32'h400);
    wait_valid();
    finish_instr(1'b0, 32'h0, 1'b0);
`endif
    check("pre_rst_retired", bus.retired, 32'd11);

    // Reset while an instruction sits in ISSUE
    bus.instr_ready = 1'b0;
    wait_valid();
    rst_n = 1'b0;
    tick();
    check("midrst_valid",   {31'h0, bus.instr_valid}, 32'h0);
    check("midrst_busy",    {31'h0, bus.busy}, 32'h0);
    check("midrst_addr",    bus.imem_addr, 32'd0);
    check("midrst_retired", bus.retired, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (2) tick();
    check("postrst_idle", {31'h0, bus.busy}, 32'h0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
